// File: rtl/uart_tx_frame_ctrl.sv
// UART/IrDA transmit frame controller: byte handshake, parity, and load/shift strobes for an 11-bit shift register.
// Optional build macro UART_TX_STOP2_EN selects two stop bits instead of one.
module uart_tx_frame_ctrl #(
    parameter int unsigned CLK_DIV    = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  tx_byte,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [10:0] frame_data,
    output logic        sr_load,
    output logic        sr_shift,
    output logic        sr_shift_in,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = 4;
    localparam int unsigned FRM_W  = 11;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(11);
    localparam logic [FRM_W-1:0]  FRAME_RESET = FRM_W'(1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, STOP, DONE} state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [FRM_W-1:0]  frame_nxt;
    logic              tx_ready_nxt, sr_load_nxt, sr_shift_nxt, busy_nxt, tx_done_nxt;
    logic              handshake;
    logic              parity;
`ifdef UART_TX_STOP2_EN
    logic              stop_second, stop_second_nxt;
`endif

    assign sr_shift_in = 1'b1;
    assign handshake   = tx_valid & tx_ready;
    assign parity      = (^tx_byte) ^ PARITY_ODD;

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            frame_data <= FRAME_RESET;
            tx_ready   <= 1'b0;
            sr_load    <= 1'b0;
            sr_shift   <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_second <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            frame_data <= frame_nxt;
            tx_ready   <= tx_ready_nxt;
            sr_load    <= sr_load_nxt;
            sr_shift   <= sr_shift_nxt;
            busy       <= busy_nxt;
            tx_done    <= tx_done_nxt;
`ifdef UART_TX_STOP2_EN
            stop_second <= stop_second_nxt;
`endif
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        frame_nxt = frame_data;
`ifdef UART_TX_STOP2_EN
        stop_second_nxt = stop_second;
`endif
        unique case (state)
            IDLE: begin
                if (handshake) begin
                    frame_nxt = {parity, tx_byte, 1'b0, 1'b1};
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                baud_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    bit_nxt  = (bit_cnt == BIT_LAST) ? bit_cnt : bit_cnt + BIT_W'(1);
                    // The final shift cycle already counts as the first stop-bit cycle
                    if (bit_cnt == BIT_LAST - BIT_W'(1)) begin
                        baud_nxt  = BAUD_W'(1);
                        state_nxt = STOP;
`ifdef UART_TX_STOP2_EN
                        stop_second_nxt = 1'b0;
`endif
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
`ifdef UART_TX_STOP2_EN
                    if (!stop_second) begin
                        stop_second_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
`else
                    state_nxt = DONE;
`endif
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state; ready waits one full IDLE cycle
    always_comb begin
        tx_ready_nxt = 1'b0;
        sr_load_nxt  = 1'b0;
        sr_shift_nxt = 1'b0;
        busy_nxt     = 1'b0;
        tx_done_nxt  = 1'b0;
        tx_ready_nxt = (state == IDLE) && (state_nxt == IDLE);
        sr_load_nxt  = (state_nxt == LOAD);
        sr_shift_nxt = (state_nxt == SEND) && (baud_nxt == BAUD_LAST);
        busy_nxt     = (state_nxt == LOAD) || (state_nxt == SEND) || (state_nxt == STOP);
        tx_done_nxt  = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: even and odd parity instances, an attached
// shift-register model, and a cycle-indexed reference of the frame timeline.
module tb_uart_tx_frame_ctrl;

    localparam int unsigned D = 4;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif
    localparam int TEND = (11 + NSTOP) * int'(D);

    logic        clock;
    logic        reset;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready, sr_load, sr_shift, sr_shift_in, busy, tx_done;
    logic [10:0] frame_data;
    logic        o_ready, o_load, o_shift, o_shift_in, o_busy, o_done;
    logic [10:0] o_frame;
    logic [10:0] sr;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_frame_ctrl #(.CLK_DIV(D), .PARITY_ODD(1'b0)) dut (
        .clock(clock), .reset(reset), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .frame_data(frame_data), .sr_load(sr_load),
        .sr_shift(sr_shift), .sr_shift_in(sr_shift_in), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_frame_ctrl #(.CLK_DIV(D), .PARITY_ODD(1'b1)) dut_odd (
        .clock(clock), .reset(reset), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(o_ready), .frame_data(o_frame), .sr_load(o_load),
        .sr_shift(o_shift), .sr_shift_in(o_shift_in), .busy(o_busy), .tx_done(o_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream shift register: outputs bit 0 on the line, fills from sr_shift_in
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        sr <= 11'h001;
        else if (sr_load)  sr <= frame_data;
        else if (sr_shift) sr <= {sr_shift_in, sr[10:1]};
    end

    task automatic check(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (t=%0d): observed 0x%0h expected 0x%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [10:0] ref_frame(input logic [7:0] b, input bit odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {((ones % 2) == 1) ^ odd, b, 1'b0, 1'b1};
    endfunction

    // Line level t cycles after the handshake cycle: idle until the first shift, then bit k of the frame, then stop
    function automatic logic ref_line(input logic [10:0] f, input int t);
        int k;
        if (t < 2) return 1'b1;
        k = (t - 2) / int'(D);
        if (k <= 10) return f[k];
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] b, input bit hold, input bit b2b);
        int waitc = 0;
        logic [10:0] f, fo;
        bit exp_shift;
        while (tx_ready !== 1'b1 && waitc < 200) begin
            @(negedge clock);
            waitc++;
        end
        check("ready_timeout", 0, 32'(waitc < 200), 32'(1));
        if (b2b) check("b2b_spacing", 0, 32'(waitc), 32'(1));
        tx_byte  = b;
        tx_valid = 1'b1;
        f  = ref_frame(b, 1'b0);
        fo = ref_frame(b, 1'b1);
        for (int t = 1; t <= TEND + 2; t++) begin
            @(negedge clock);
            exp_shift = (t > 1) && (((t - 1) % int'(D)) == 0) && (((t - 1) / int'(D)) <= 11);
            check("sr_load",    t, 32'(sr_load),    32'(t == 1));
            check("sr_shift",   t, 32'(sr_shift),   32'(exp_shift));
            check("busy",       t, 32'(busy),       32'(t <= TEND));
            check("tx_done",    t, 32'(tx_done),    32'(t == TEND + 1));
            check("tx_ready",   t, 32'(tx_ready),   32'(0));
            check("frame_even", t, 32'(frame_data), 32'(f));
            check("frame_odd",  t, 32'(o_frame),    32'(fo));
            check("line",       t, 32'(sr[0]),      32'(ref_line(f, t)));
            tx_byte = 8'($urandom);
            if (!hold) tx_valid = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [7:0] rb;
        int t;
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("rst_ready",    0, 32'(tx_ready),    32'(0));
        check("rst_frame",    0, 32'(frame_data),  32'(11'h001));
        check("rst_load",     0, 32'(sr_load),     32'(0));
        check("rst_shift",    0, 32'(sr_shift),    32'(0));
        check("rst_shift_in", 0, 32'(sr_shift_in), 32'(1));
        check("rst_busy",     0, 32'(busy),        32'(0));
        check("rst_done",     0, 32'(tx_done),     32'(0));
        reset = 1'b1;
        #1;
        check("rel_ready_low", 0, 32'(tx_ready), 32'(0));
        @(negedge clock);
        check("rel_ready_high", 0, 32'(tx_ready), 32'(1));

        run_frame(8'hA5, 1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (3) @(negedge clock);
        run_frame(8'h07, 1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (2) @(negedge clock);
        run_frame(8'h55, 1'b1, 1'b0);
        run_frame(8'h3C, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rb = 8'($urandom);
            run_frame(rb, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Abandon a frame at its 5th shift pulse
        tx_valid = 1'b0;
        repeat (2) @(negedge clock);
        tx_byte  = 8'($urandom);
        tx_valid = 1'b1;
        t = 0;
        while (t < 1 + 5 * int'(D)) begin
            @(negedge clock);
            t++;
        end
        check("mid_shift5", t, 32'(sr_shift), 32'(1));
        tx_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("mid_busy",     0, 32'(busy),       32'(0));
        check("mid_shift",    0, 32'(sr_shift),   32'(0));
        check("mid_done",     0, 32'(tx_done),    32'(0));
        check("mid_load",     0, 32'(sr_load),    32'(0));
        check("mid_ready",    0, 32'(tx_ready),   32'(0));
        check("mid_frame",    0, 32'(frame_data), 32'(11'h001));
        check("mid_frame_o",  0, 32'(o_frame),    32'(11'h001));
        check("mid_line",     0, 32'(sr[0]),      32'(1));
        repeat (3) begin
            @(negedge clock);
            check("rst_hold_done", 0, 32'(tx_done), 32'(0));
        end
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 0, 32'(tx_ready), 32'(1));
        for (int i = 0; i < 2 * int'(D); i++) begin
            check("post_rst_done", i, 32'(tx_done), 32'(0));
            check("post_rst_busy", i, 32'(busy),    32'(0));
            @(negedge clock);
        end
        rb = 8'($urandom);
        run_frame(rb, 1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (4) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
